// File: rtl/interleave_buffer.sv
// Ping-pong block interleaver: N samples are written into one bank in order
// while the other bank drains with a cyclic +1 (forward) or -1 (reverse) shift.
module interleave_buffer #(
    parameter int N = 10,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         out_mode
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_e;

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic [1:0]    mode_q, mode_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [IW-1:0] wi_q, wi_d;
    logic [IW-1:0] ri_q, ri_d;
    logic [W-1:0]  mem_q [2][N];
    logic [W-1:0]  mem_d [2][N];

    logic          in_fire;
    logic          out_fire;
    logic [IW-1:0] rd_idx;

    assign in_ready  = (state_q[wb_q] == EMPTY) || (state_q[wb_q] == FILLING);
    assign out_valid = (state_q[rb_q] == FULL) || (state_q[rb_q] == DRAINING);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Read address: neighbour of ri selected by the draining bank's mode
    always_comb begin
        rd_idx = '0;
        if (mode_q[rb_q]) begin
            rd_idx = (ri_q == '0) ? LAST_IDX : ri_q - IW'(1);
        end else begin
            rd_idx = (ri_q == LAST_IDX) ? '0 : ri_q + IW'(1);
        end
    end

    assign out_data = mem_q[rb_q][rd_idx];
    assign out_last = out_valid && (ri_q == LAST_IDX);
    assign out_mode = mode_q[rb_q];

    // Bank state and pointer next-state; in_ready/out_valid are mutually
    // exclusive per bank, so a simultaneous write and read never hit one bank
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wb_d    = wb_q;
        rb_d    = rb_q;
        wi_d    = wi_q;
        ri_d    = ri_q;
        if (out_fire) begin
            if (ri_q == LAST_IDX) begin
                state_d[rb_q] = EMPTY;
                ri_d          = '0;
                rb_d          = ~rb_q;
            end else begin
                state_d[rb_q] = DRAINING;
                ri_d          = ri_q + IW'(1);
            end
        end
        if (in_fire) begin
            if (wi_q == '0) begin
                mode_d[wb_q] = in_mode;
            end
            if (wi_q == LAST_IDX) begin
                state_d[wb_q] = FULL;
                wi_d          = '0;
                wb_d          = ~wb_q;
            end else begin
                state_d[wb_q] = FILLING;
                wi_d          = wi_q + IW'(1);
            end
        end
    end

    // Sample storage write: sample k of a block lands at index k
    always_comb begin
        mem_d = mem_q;
        if (in_fire) begin
            mem_d[wb_q][wi_q] = in_data;
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            mode_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wi_q       <= '0;
            ri_q       <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            wi_q    <= wi_d;
            ri_q    <= ri_d;
        end
    end

    // Sample storage registers, intentionally not reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_interleave_buffer.sv
// Scoreboard bench for interleave_buffer: expected permuted blocks are queued
// as inputs are accepted and popped as the DUT emits samples.
module tb_interleave_buffer;

    localparam int N = 10;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_mode;

    interleave_buffer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        logic         m;
    } exp_t;

    int           vectors = 0;
    int           miscompares = 0;
    exp_t         sb [$];
    logic [W-1:0] got_log [$];
    logic [W-1:0] blk [N];
    int           bcnt = 0;
    logic         bmode = 1'b0;
    bit           bp_en = 1'b0;
    int           stalls = 0;
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_d = '0;
    logic         held_l = 1'b0;

    int exp_fwd [N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    int exp_rev [N] = '{9, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    int exp_id  [N] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_log(input string tag, input int e [N]);
        check({tag, "_len"}, got_log.size(), N);
        for (int i = 0; i < N && i < got_log.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got_log[i], e[i]);
    endtask

    // Output monitor: scoreboard pop on transfer, hold-stability check on stall
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && out_valid) begin
                    check("hold_data", out_data, held_d);
                    check("hold_last", out_last, held_l);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_last", out_last, e.l);
                        check("out_mode", out_mode, e.m);
                    end
                    got_log.push_back(out_data);
                end
                stall_prev = out_valid && !out_ready;
                held_d     = out_data;
                held_l     = out_last;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic m);
        int   t;
        exp_t e;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!in_ready) begin
            stalls++;
            t++;
            if (t > 300) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(posedge clk);
        blk[bcnt] = d;
        if (bcnt == 0) bmode = m;
        bcnt++;
        if (bcnt == N) begin
            for (int i = 0; i < N; i++) begin
                e.d = bmode ? blk[(i + N - 1) % N] : blk[(i + 1) % N];
                e.l = (i == N - 1);
                e.m = bmode;
                sb.push_back(e);
            end
            bcnt = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && t < 500) begin
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", sb.size(), 0);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_last", out_last, 0);
        check("rst_out_mode", out_mode, 0);
        sb.delete();
        got_log.delete();
        bcnt = 0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset values
        #1;
        check("por_out_valid", out_valid, 0);
        check("por_in_ready", in_ready, 1);
        check("por_out_last", out_last, 0);
        check("por_out_mode", out_mode, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Forward block, one-cycle latency
        for (int i = 0; i < N - 1; i++) send(W'(i), 1'b0);
        check("s1_lat_pre", out_valid, 0);
        send(W'(N - 1), 1'b0);
        check("s1_lat", out_valid, 1);
        drain();
        check_log("s1_fwd", exp_fwd);

        // Reverse block, then reverse undoes forward
        got_log.delete();
        for (int i = 0; i < N; i++) send(W'(i), 1'b1);
        drain();
        check_log("s2_rev", exp_rev);
        got_log.delete();
        for (int i = 0; i < N; i++) send(W'(exp_fwd[i]), 1'b1);
        drain();
        check_log("s2_inv", exp_id);

        // Both banks full under backpressure, then release
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(W'(i), 1'((i / N) % 2));
        check("s3_full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 8'd20;
        repeat (5) begin
            @(negedge clk);
            check("s3_stall_ready", in_ready, 0);
            check("s3_stall_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 2 * N; i < 3 * N; i++) send(W'(i), 1'b0);
        drain();

        // Continuous stream, alternating modes, no bubbles
        do_reset();
        stalls = 0;
        for (int i = 0; i < 5 * N; i++) send(W'(i + 100), 1'((i / N) % 2));
        in_valid = 1'b0;
        check("s4_bubbles", stalls, 0);
        drain();

        // Random backpressure and input gaps, mode varying within a block
        do_reset();
        bp_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
        end
        drain();
        bp_en = 1'b0;
        out_ready = 1'b1;

        // Reset with a partial block filling and a full block draining
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(W'(i + 50), 1'b0);
        for (int i = 0; i < 4; i++) send(W'(i + 60), 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        do_reset();
        repeat (15) begin
            @(negedge clk);
            check("s6_no_stale", out_valid, 0);
        end
        check("s6_log_empty", got_log.size(), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) send(W'(i), 1'b0);
        drain();
        check_log("s6_fresh", exp_fwd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interleave_buffer.md
INTERLEAVE_BUFFER -- requirements
Module: interleave_buffer

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning the number of samples per block (N >= 2).
REQ-002 The block SHALL have parameter W, default 8, meaning the width of one soft sample in bits.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream sample valid.
REQ-006 Port in_ready  output  1  block can accept a sample this cycle.
REQ-007 Port in_data  input  W  input sample.
REQ-008 Port in_mode  input  1  permutation select (0 = forward, 1 = reverse), sampled with the first sample of each block.
REQ-009 Port out_valid  output  1  output sample valid.
REQ-010 Port out_ready  input  1  downstream accepts the sample.
REQ-011 Port out_data  output  W  permuted output sample.
REQ-012 Port out_last  output  1  high with the N-th output sample of a block.
REQ-013 Port out_mode  output  1  mode latched for the block currently draining.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Storage SHALL be two banks (ping-pong) of N x W registers, each with state EMPTY, FILLING, FULL or DRAINING, plus one latched mode bit.
REQ-016 Write pointer: the bank and write index wi (0..N-1) SHALL advance per input transfer; wi wraps N-1 -> 0 and toggles the write bank.
REQ-017 Input sample k of a block SHALL be stored at bank index k.
REQ-018 The first input transfer of a block SHALL latch in_mode into that bank and move the bank EMPTY -> FILLING.
REQ-019 The N-th input transfer SHALL move the bank to FULL.
REQ-020 in_ready SHALL be 1 only when the write bank is EMPTY or FILLING; it is a function of registered state only.
REQ-021 Read pointer: the read bank and read index ri (0..N-1) SHALL advance per output transfer.
REQ-022 out_valid SHALL be 1 when the read bank is FULL or DRAINING; the first output transfer moves the bank FULL -> DRAINING.
REQ-023 Forward mode: out_data SHALL equal stored[(ri+1) mod N].
REQ-024 Reverse mode: out_data SHALL equal stored[(ri+N-1) mod N], so that reverse exactly inverts forward.
REQ-025 out_last SHALL be 1 when ri = N-1. out_mode SHALL be the read bank's latched mode.
REQ-026 The output transfer with ri = N-1 SHALL set the bank to EMPTY on that clock edge, wrap ri to 0 and toggle the read bank.
REQ-027 The freed bank SHALL be writable on the next cycle; there SHALL be no same-cycle bypass from output to input.
REQ-028 Latency: out_valid SHALL rise in the cycle after the N-th input transfer of a block (1 cycle).
REQ-029 With in_valid=1 and out_ready=1 held, throughput SHALL be sustained at 1 sample/cycle with no in_ready gaps after the first block.
REQ-030 When both banks are FULL or DRAINING, in_ready SHALL be 0 and input SHALL be stalled without loss.
REQ-031 out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 Simultaneous input and output transfers on different banks SHALL both complete in the same cycle.

Reset
REQ-033 Asserting reset SHALL asynchronously set:
  - both banks to EMPTY;
  - wi, ri, write bank and read bank to 0;
  - out_valid, out_last and out_mode to 0;
  - in_ready to 1.
REQ-034 Sample storage SHALL NOT be required to reset.
REQ-035 Reset mid-block SHALL discard all partial and full blocks; no stale sample is ever output afterwards.

Verification
REQ-036 Scenario 1: reset, then send 0..9 with mode=0 and out_ready=1 -> out_valid rises 1 cycle after the 10th input; output is 1,2,...,9,0; out_last is set on the sample 0.
REQ-037 Scenario 2: same stimulus with mode=1 -> output is 9,0,1,...,8; feeding the scenario-1 output through in reverse mode returns 0..9.
REQ-038 Scenario 3: out_ready=0, stream 25 samples -> in_ready drops after the 20th input; after out_ready=1, the 20 stored samples appear in order with no loss or duplication.
REQ-039 Scenario 4: continuous 50-sample stream with alternating block modes and out_ready=1 -> in_ready stays 1 after reset; each block is permuted per its own mode; 0 bubbles after the first block.
REQ-040 Scenario 5: random out_ready backpressure -> out_data and out_last are stable while stalled; a scoreboard matches the reference permutation.
REQ-041 Scenario 6: assert reset after 4 inputs of a block and during the drain of a full block -> out_valid is 0 immediately; after release, a fresh block of 10 samples outputs correctly.
